sg_scheduler: RTL and testbench
===============================

# sg_scheduler

Round-robin scheduler that shares the single signal-generator (SG) instance among up to `N_REQ` requesters. Each requester asks for a burst of a programmed length. The scheduler grants one requester at a time, pulses the SG reset, then holds the SG `start` level for exactly the requested number of cycles. After an enforced idle gap it serves the next requester. The block sits between the requesting blocks and the SG's `rst`/`start` inputs.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `LEN_W`, 16: width of each burst-length field.
- `GAP_CYC`, 4: idle cycles between consecutive bursts (0 allowed).

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  reset; synchronous, active-low.
- `req`  in  N_REQ  per-requester level request.
- `len`  in  N_REQ*LEN_W  burst lengths; requester i uses bits [i*LEN_W +: LEN_W].
- `gnt`  out  N_REQ  one-hot grant, high from PREP through RUN.
- `done`  out  N_REQ  one-cycle pulse to the served requester at burst end.
- `owner`  out  $clog2(N_REQ)  index of current/last granted requester.
- `busy`  out  1  high in any state other than IDLE.
- `sg_rst`  out  1  active-high reset to SG.
- `sg_start`  out  1  start level to SG.

## Operation
- All outputs are registered. After reset, every output is 0, state is IDLE, the RR pointer is 0 and the counter is 0.
- **IDLE**
  - If `req` is nonzero: select the winner as the first set bit scanning from `ptr` upward, modulo N_REQ.
  - On that edge: latch `owner`, load `cnt` with `len[owner]`, set `gnt` one-hot, set `sg_rst`=1, set `ptr`=owner+1 mod N_REQ, and go to PREP.
- **PREP** (exactly 1 cycle, `sg_rst`=1)
  - Next edge: `sg_rst`=0.
  - If `cnt`==0: set `done[owner]`=1, `gnt`=0, and go to GAP. This is a zero-length burst; `sg_start` is never raised.
  - Otherwise: set `sg_start`=1 and go to RUN.
- **RUN**
  - `cnt` decrements every cycle.
  - On the edge where `cnt`==1: set `sg_start`=0, `gnt`=0, `done[owner]`=1, and go to GAP.
  - `sg_start` is therefore high for exactly `len` cycles.
- **GAP**
  - Counts GAP_CYC cycles, then returns to IDLE.
  - If GAP_CYC==0, the next edge goes to IDLE.
  - `done` is cleared after 1 cycle.
- `len` is sampled only at grant. Later changes to it have no effect on the current burst.
- Without the abort feature, `req` is ignored after grant; dropping it does not shorten the burst.
- `req` bits that are still high when IDLE is re-entered are served again in RR order. Requesters deassert `req` upon seeing `done`.
- Simultaneous requests are served in RR order starting at `ptr`; no requester waits more than N_REQ-1 bursts.
- Reset asserted in any state returns to IDLE on that edge, with all outputs 0 and `ptr`=0. An in-flight burst is dropped without `done`.

## Timing
- Grant latency: `req` is sampled high at edge E0 in IDLE, so `gnt`/`sg_rst` are high from E0.
- `sg_rst` is high for cycle [E0,E1).
- `sg_start` is high for [E1, E1+len).
- `done` is high for [E1+len, E1+len+1), the first cycle `sg_start` is low.
- `busy` is high from E0 until IDLE is re-entered at E1+len+GAP_CYC.
- Zero-length burst: `done` is high in [E1,E1+1).
- Back-to-back throughput: one burst per len+GAP_CYC+2 cycles.

## Configuration
- **`SG_SCHED_ABORT_EN` defined:** in RUN, if `req[owner]` is sampled low, the burst aborts on that edge.
  - `sg_start`=0, `gnt`=0, `done[owner]`=1, go to GAP.
  - The sticky output `aborted` (1 bit, added port) is set high until the next grant.
  - `aborted` resets to 0.
- **Not defined:** `req[owner]` is ignored during RUN, the `aborted` port does not exist, and bursts always run their full length.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles with `req`=4'b1111. All outputs stay 0 and `busy`=0.
- **Single burst:** requester 2, `len`=5, GAP_CYC=4.
  - `sg_rst` is high for 1 cycle.
  - `sg_start` is high for exactly 5 cycles.
  - `done`=4'b0100 for 1 cycle immediately after.
  - `busy` drops 4 cycles later.
- **Contention:** `req`=4'b1011 held, with each requester dropping `req` on its `done`. Grants occur in order 0, 1, 3. The next session with `req`=4'b0001 grants 0 because `ptr` wrapped to 0.
- **Zero length:** requester 1 with `len`=0. `sg_rst` pulses, `sg_start` never rises, and `done[1]` pulses one cycle after `sg_rst`.
- **Reset mid-burst:** `rst`=0 during the 3rd RUN cycle of a `len`=10 burst. On that edge `sg_start`=0 and `gnt`=0, no `done` is produced, and the next request is granted from `ptr`=0.
- **Abort (`SG_SCHED_ABORT_EN` only):** `len`=100, drop `req[0]` after 7 `sg_start` cycles. `sg_start` falls on the sampling edge, `done[0]` pulses, and `aborted`=1 until the next grant.

Source files
------------

// File: rtl/sg_scheduler.sv
// sg_scheduler: round-robin arbiter sharing one signal generator among N_REQ
// requesters. Each grant pulses sg_rst for one cycle, holds sg_start for the
// requested burst length, pulses done to the owner, then idles GAP_CYC cycles.
// Optional build macro SG_SCHED_ABORT_EN: dropping req[owner] during a burst
// ends it early and sets the sticky 'aborted' output until the next grant.
module sg_scheduler #(
  parameter int N_REQ   = 4,
  parameter int LEN_W   = 16,
  parameter int GAP_CYC = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*LEN_W-1:0]   len,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     sg_rst,
  output logic                     sg_start
`ifdef SG_SCHED_ABORT_EN
  ,
  output logic                     aborted
`endif
);

  localparam int OW = $clog2(N_REQ);
  localparam int GW = (GAP_CYC < 1) ? 1 : $clog2(GAP_CYC + 1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_RUN, S_GAP} state_t;

  state_t            state_q;
  logic [OW-1:0]     ptr_q;
  logic [LEN_W-1:0]  cnt_q;
  logic [GW-1:0]     gcnt_q;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  done_q;
  logic [OW-1:0]     owner_q;
  logic              busy_q;
  logic              sg_rst_q;
  logic              sg_start_q;
  logic              aborted_q;

  logic [OW-1:0]     idx_c;
  logic [OW-1:0]     win_d;
  logic              hit_d;
  logic [LEN_W-1:0]  len_sel_d;
  logic [OW-1:0]     ptr_nxt_d;
  logic              abort_d;
  logic              run_end_d;

  // Winner search: first requesting index at or after ptr, wrapping modulo N_REQ
  always_comb begin
    idx_c     = '0;
    win_d     = '0;
    hit_d     = 1'b0;
    len_sel_d = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx_c = OW'((32'(ptr_q) + k) % N_REQ);
      if (!hit_d && req[idx_c]) begin
        hit_d = 1'b1;
        win_d = idx_c;
      end
    end
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_d == OW'(i)) len_sel_d = len[i*LEN_W +: LEN_W];
    end
    ptr_nxt_d = (win_d == OW'(N_REQ - 1)) ? '0 : win_d + OW'(1);
  end

  // Burst termination: natural end on the last count, or early abort when enabled
  always_comb begin
`ifdef SG_SCHED_ABORT_EN
    abort_d = !req[owner_q];
`else
    abort_d = 1'b0;
`endif
    run_end_d = abort_d || (cnt_q == LEN_W'(1));
  end

  // Scheduler FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      gcnt_q     <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
      sg_rst_q   <= 1'b0;
      sg_start_q <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (hit_d) begin
            owner_q   <= win_d;
            cnt_q     <= len_sel_d;
            gnt_q     <= N_REQ'(1) << win_d;
            sg_rst_q  <= 1'b1;
            ptr_q     <= ptr_nxt_d;
            busy_q    <= 1'b1;
            aborted_q <= 1'b0;
            state_q   <= S_PREP;
          end
        end
        S_PREP: begin
          sg_rst_q <= 1'b0;
          if (cnt_q == '0) begin
            done_q  <= gnt_q;
            gnt_q   <= '0;
            gcnt_q  <= GW'(GAP_CYC);
            state_q <= S_GAP;
          end else begin
            sg_start_q <= 1'b1;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - LEN_W'(1);
          if (run_end_d) begin
            sg_start_q <= 1'b0;
            done_q     <= gnt_q;
            gnt_q      <= '0;
            gcnt_q     <= GW'(GAP_CYC);
            if (abort_d) aborted_q <= 1'b1;
            state_q    <= S_GAP;
          end
        end
        S_GAP: begin
          // a zero gap still spends one cycle here before returning to IDLE
          if (gcnt_q <= GW'(1)) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            gcnt_q <= gcnt_q - GW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign owner    = owner_q;
  assign busy     = busy_q;
  assign sg_rst   = sg_rst_q;
  assign sg_start = sg_start_q;
`ifdef SG_SCHED_ABORT_EN
  assign aborted  = aborted_q;
`endif

endmodule

// File: tb/tb_sg_scheduler.sv
// Testbench for sg_scheduler: timing-level reference model feeding a scoreboard
// queue, independent negedge monitor, directed scenarios plus random requesters.
module tb_sg_scheduler;
  localparam int N = 4;
  localparam int W = 16;
  localparam int G = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [N-1:0]             req = '0;
  logic [N*W-1:0]           len = '0;
  logic [N-1:0]             gnt;
  logic [N-1:0]             done;
  logic [$clog2(N)-1:0]     owner;
  logic                     busy;
  logic                     sg_rst;
  logic                     sg_start;
`ifdef SG_SCHED_ABORT_EN
  logic                     aborted;
`endif

  sg_scheduler #(.N_REQ(N), .LEN_W(W), .GAP_CYC(G)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .len      (len),
    .gnt      (gnt),
    .done     (done),
    .owner    (owner),
    .busy     (busy),
    .sg_rst   (sg_rst),
    .sg_start (sg_start)
`ifdef SG_SCHED_ABORT_EN
    ,
    .aborted  (aborted)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int own;
    int blen;
    int e0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // reference model state (edge-indexed timing of the published protocol)
  int   k = 0;
  bit   rst_edge = 1'b0;
  int   m_ptr = 0;
  int   last_busy = -1;
  int   next_ok = 0;
  bit   m_abrt = 1'b0;
  bit   cur_act = 1'b0;
  int   cur_own = 0, cur_e0 = 0, cur_len = 0;
  int   own, lv, idx, eff;
  bit   found;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, k);
    end
  endtask

  // Model: at each edge decide grants, aborts and resets from the rules
  always @(posedge clk) begin
    k++;
    rst_edge = !rst;
    if (!rst) begin
      m_ptr = 0; last_busy = -1; next_ok = k + 1;
      m_abrt = 1'b0; cur_act = 1'b0;
      sb.delete();
    end else begin
      if (cur_act && k > cur_e0 + 1 + cur_len) cur_act = 1'b0;
`ifdef SG_SCHED_ABORT_EN
      if (cur_act && cur_len > 0 && k >= cur_e0 + 2 && k <= cur_e0 + 1 + cur_len
          && !req[cur_own]) begin
        eff = k - cur_e0 - 1;
        sb[sb.size()-1].blen = eff;
        last_busy = cur_e0 + eff + G;
        next_ok = last_busy + 2;
        cur_act = 1'b0;
        m_abrt = 1'b1;
      end
`endif
      if (k >= next_ok && req != '0) begin
        found = 1'b0; own = 0;
        for (int j = 0; j < N; j++) begin
          idx = (m_ptr + j) % N;
          if (!found && req[idx]) begin found = 1'b1; own = idx; end
        end
        lv = int'(len[own*W +: W]);
        sb.push_back('{own: own, blen: lv, e0: k});
        m_ptr = (own + 1) % N;
        last_busy = k + lv + G;
        next_ok = k + lv + G + 2;
        cur_act = 1'b1; cur_own = own; cur_e0 = k; cur_len = lv;
        m_abrt = 1'b0;
      end
    end
  end

  // Monitor: per-cycle busy/reset checks; pops the scoreboard on every done
  int n_start = 0, n_rst = 0;
  always @(negedge clk) begin
    if (k > 0) begin
      if (rst_edge) begin
        chk({gnt, done, owner, busy, sg_rst, sg_start} == '0, "reset_outputs",
            {gnt, done, owner, busy, sg_rst, sg_start}, 0);
`ifdef SG_SCHED_ABORT_EN
        chk(aborted == 1'b0, "reset_aborted", aborted, 0);
`endif
        n_start = 0; n_rst = 0;
      end else begin
        chk(busy == (k <= last_busy), "busy", busy, k <= last_busy);
`ifdef SG_SCHED_ABORT_EN
        chk(aborted == m_abrt, "aborted", aborted, m_abrt);
`endif
        if (sg_rst) begin
          n_rst++;
          if (sb.size() > 0)
            chk(gnt == (1 << sb[sb.size()-1].own), "gnt_onehot", gnt, 1 << sb[sb.size()-1].own);
          else
            chk(1'b0, "grant_unexpected", gnt, 0);
        end
        if (sg_start) n_start++;
        if (done != '0) begin
          if (sb.size() == 0) begin
            chk(1'b0, "done_unexpected", done, 0);
          end else begin
            mon_e = sb.pop_front();
            chk(done == (1 << mon_e.own), "done_onehot", done, 1 << mon_e.own);
            chk(owner == mon_e.own, "owner", owner, mon_e.own);
            chk(n_start == mon_e.blen, "start_cycles", n_start, mon_e.blen);
            chk(n_rst == 1, "sg_rst_cycles", n_rst, 1);
            chk(k == mon_e.e0 + 1 + mon_e.blen, "done_edge", k, mon_e.e0 + 1 + mon_e.blen);
            chk(sg_start == 1'b0, "start_low_at_done", sg_start, 0);
          end
          n_start = 0; n_rst = 0;
        end
      end
    end
  end

  // Requesters drop req on done; a granted requester's len is scrambled afterwards
  task automatic step();
    @(negedge clk);
    req = req & ~done;
    for (int i = 0; i < N; i++)
      if (gnt[i]) len[i*W +: W] = W'($urandom_range(0, 30));
  endtask

  task automatic setlen(input int i, input int v);
    len[i*W +: W] = W'(v);
  endtask

  task automatic wait_quiet(input int maxc, input string nm);
    int c = 0;
    while ((req != '0 || busy) && c < maxc) begin
      step();
      c++;
    end
    chk(c < maxc, nm, c, maxc);
  endtask

  task automatic wait_start(input int maxc, input string nm);
    int c = 0;
    while (!sg_start && c < maxc) begin
      step();
      c++;
    end
    chk(c < maxc, nm, c, maxc);
  endtask

  initial begin
    // reset held with all requests high
    rst = 1'b0; req = '1;
    repeat (3) step();
    rst = 1'b1; req = '0;

    // contention 0,1,3 then wrap to 0
    for (int i = 0; i < N; i++) setlen(i, $urandom_range(1, 6));
    req = 4'b1011;
    wait_quiet(200, "contention_timeout");
    setlen(0, 3);
    req = 4'b0001;
    wait_quiet(100, "wrap_timeout");

    // single burst
    setlen(2, 5);
    req = 4'b0100;
    wait_quiet(100, "single_timeout");

    // zero-length burst
    setlen(1, 0);
    req = 4'b0010;
    wait_quiet(100, "zero_timeout");

    // reset during 3rd RUN cycle, then ptr restarts at 0
    setlen(0, 10);
    req = 4'b0001;
    wait_start(50, "midrst_start_timeout");
    repeat (2) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    setlen(0, 3); setlen(1, 2);
    req = 4'b0011;
    wait_quiet(200, "post_reset_timeout");

`ifdef SG_SCHED_ABORT_EN
    // abort after 7 sg_start cycles, then a fresh grant clears aborted
    setlen(0, 100);
    req = 4'b0001;
    wait_start(50, "abort_start_timeout");
    repeat (6) step();
    req[0] = 1'b0;
    repeat (3) step();
    setlen(2, 2);
    req = 4'b0100;
    wait_quiet(100, "abort_timeout");
`endif

    // random requesters
    repeat (1500) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 5) == 0) begin
          setlen(i, $urandom_range(0, 12));
          req[i] = 1'b1;
        end
      end
    end
    wait_quiet(600, "drain_timeout");
    chk(sb.size() == 0, "scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
